// File: rtl/mem_copy_engine_if.sv
// Bus bundle for the memory copy engine: the start/operand/status handshake
// toward the requester plus the single read/write memory port.
interface mem_copy_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [6:0]    len;
    logic          busy;
    logic          done;
    logic          error;
    logic [6:0]    words_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_read_data;

    // Engine side: drives memory strobes and status, consumes requests and read data.
    modport master (
        input  start, src_addr, dst_addr, len, mem_read_data,
        output busy, done, error, words_done,
        output mem_addr, mem_write_data, mem_write, mem_read
    );

    // Requester/memory side: the mirror image of the engine.
    modport slave (
        output start, src_addr, dst_addr, len, mem_read_data,
        input  busy, done, error, words_done,
        input  mem_addr, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: copies len words from src to dst through one memory
// port, alternating a read cycle and a write cycle per word in ascending
// order. Range violations and zero-length requests finish without touching
// memory. Every output is decoded from registered state only.
module mem_copy_engine #(
    parameter int DEPTH = 64,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic             clk,
    input logic             rst,
    mem_copy_engine_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [6:0]    len_q, len_d;
    logic [6:0]    idx_q, idx_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          err_q, err_d;

    // End addresses of both regions, one bit wider so they cannot wrap.
    logic [AW:0]   src_end;
    logic [AW:0]   dst_end;
    logic          range_bad;
    logic [6:0]    idx_inc;

    // Range check on the live request operands, only consumed in IDLE.
    always_comb begin
        src_end   = {1'b0, bus.src_addr} + {{(AW - 6){1'b0}}, bus.len};
        dst_end   = {1'b0, bus.dst_addr} + {{(AW - 6){1'b0}}, bus.len};
        range_bad = (src_end > DEPTH_EXT) || (dst_end > DEPTH_EXT);
        idx_inc   = idx_q + 7'd1;
    end

    // State and datapath registers; async reset returns everything to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept in IDLE, read/write per word, one DONE cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d = bus.src_addr;
                    dst_d = bus.dst_addr;
                    len_d = bus.len;
                    idx_d = '0;
                    err_d = 1'b0;
                    if (bus.len == 7'd0) begin
                        state_d = DONE;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d   = bus.mem_read_data;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? DONE : READ;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state, buffer and index only.
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.error          = 1'b0;
        bus.words_done     = idx_q;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        bus.mem_write      = 1'b0;
        bus.mem_read       = 1'b0;
        unique case (state_q)
            READ: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_q + AW'(idx_q);
                bus.mem_read = 1'b1;
            end
            WRITE: begin
                bus.busy           = 1'b1;
                bus.mem_addr       = dst_q + AW'(idx_q);
                bus.mem_write_data = buf_q;
                bus.mem_write      = 1'b1;
            end
            DONE: begin
                bus.done  = 1'b1;
                bus.error = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random
// copies, compared against an array-level reference of the copy rules.
module tb_mem_copy_engine;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    logic init_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_addr = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_copy_engine_if #(.AW(AW), .DW(DW)) bus ();

    mem_copy_engine #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: combinational read, write committed at posedge.
    assign bus.mem_read_data = mem[bus.mem_addr[5:0]];

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 5) ? 32'd7 : DW'(i % 32);
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_write_data;
        end
    end

    always @(negedge clk) begin
        if ((bus.mem_read || bus.mem_write) && bus.mem_addr >= DEPTH) bad_addr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_image();
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i == 5) ? 32'd7 : 32'(i % 32);
    endtask

    // Reference: ascending word-by-word copy, so overlap smears naturally.
    task automatic ref_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, output bit err);
        longint unsigned s, d;
        s = src;
        d = dst;
        err = 1'b0;
        if (len == 0) return;
        if (s + longint'(len) > DEPTH || d + longint'(len) > DEPTH) begin
            err = 1'b1;
            return;
        end
        for (int k = 0; k < len; k++) ref_mem[int'(d) + k] = ref_mem[int'(s) + k];
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("%s_mem[%0d]", tag, i), mem[i], ref_mem[i]);
    endtask

    task automatic do_op(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input int len, input bit poke);
        bit e, seen;
        int cyc, writes, reads, busys, extra, n;
        ref_copy(src, dst, len, e);
        n = (e || len == 0) ? 0 : len;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.len      = 7'(len);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.src_addr = $urandom;
        bus.dst_addr = $urandom;
        bus.len      = 7'($urandom);
        seen = 1'b0; cyc = 1; writes = 0; reads = 0; busys = 0;
        while (!seen && cyc <= 200) begin
            if (poke && cyc == 3) begin
                bus.start    = 1'b1;
                bus.src_addr = 32'd50;
                bus.dst_addr = 32'd2;
                bus.len      = 7'd3;
            end
            if (poke && cyc == 4) bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                check({tag, "_error"}, 32'(bus.error), 32'(e));
                check({tag, "_words_done"}, 32'(bus.words_done), 32'(n));
            end else begin
                if (bus.mem_write) writes++;
                if (bus.mem_read) reads++;
                if (bus.busy) busys++;
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(2 * n + 1));
        check({tag, "_writes"}, 32'(writes), 32'(n));
        check({tag, "_reads"}, 32'(reads), 32'(n));
        check({tag, "_busy_cycles"}, 32'(busys), 32'(2 * n));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        if (poke) begin
            extra = 0;
            repeat (20) begin
                if (bus.done || bus.mem_write || bus.mem_read) extra++;
                @(negedge clk);
            end
            check({tag, "_ignored_start"}, 32'(extra), 32'd0);
        end
        check_mem(tag);
    endtask

    logic [31:0] basic_exp [8];

    initial begin
        bit e;
        int len;
        logic [31:0] s, d;
        basic_exp = '{0, 1, 2, 3, 4, 7, 6, 7};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_words_done", 32'(bus.words_done), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic copy with known contents.
        load_image();
        do_op("basic", 32'd0, 32'd40, 8, 1'b0);
        for (int k = 0; k < 8; k++)
            check($sformatf("basic_const[%0d]", 40 + k), mem[40 + k], basic_exp[k]);

        load_image();
        do_op("zero_len", 32'd7, 32'd30, 0, 1'b0);

        load_image();
        do_op("range_err", 32'd60, 32'd0, 8, 1'b0);
        do_op("after_err", 32'd56, 32'd0, 8, 1'b0);
        for (int k = 0; k < 8; k++)
            check($sformatf("after_err_const[%0d]", k), mem[k], 32'(24 + k));
        do_op("wrap_err", 32'hFFFF_FFFC, 32'd0, 8, 1'b0);
        do_op("dst_err", 32'd0, 32'd57, 8, 1'b0);

        load_image();
        do_op("overlap", 32'd0, 32'd1, 4, 1'b0);
        for (int k = 0; k < 5; k++)
            check($sformatf("overlap_const[%0d]", k), mem[k], 32'd0);
        check("overlap_const[5]", mem[5], 32'd7);

        load_image();
        do_op("full", 32'd0, 32'd0, 64, 1'b0);
        do_op("full_err", 32'd1, 32'd0, 64, 1'b0);
        do_op("edge", 32'd0, 32'd63, 1, 1'b0);

        load_image();
        do_op("busy_start", 32'd8, 32'd16, 6, 1'b1);

        // Reset during the fourth READ cycle of an 8-word copy.
        load_image();
        ref_copy(32'd0, 32'd40, 3, e);
        @(negedge clk);
        bus.start = 1'b1; bus.src_addr = 32'd0; bus.dst_addr = 32'd40; bus.len = 7'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_in_read", 32'(bus.mem_read), 32'd1);
        check("mid_rst_read_addr", bus.mem_addr, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_error", 32'(bus.error), 32'd0);
        check("mid_rst_words_done", 32'(bus.words_done), 32'd0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
        check("mid_rst_wdata", bus.mem_write_data, 32'd0);
        check("mid_rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("mid_rst_const[%0d]", 40 + k), mem[40 + k], 32'(k));
        check("mid_rst_const[43]", mem[43], 32'd11);
        check_mem("mid_rst");
        do_op("post_rst_copy", 32'd0, 32'd40, 8, 1'b0);

        // Random copies, occasionally out of range.
        load_image();
        repeat (20) begin
            len = $urandom_range(64, 0);
            if ($urandom_range(9, 0) == 0) s = $urandom_range(80, 0);
            else s = $urandom_range(64 - len, 0);
            if ($urandom_range(9, 0) == 0) d = $urandom_range(80, 0);
            else d = $urandom_range(64 - len, 0);
            do_op("rand", s, d, len, 1'b0);
        end

        check("addr_in_range", 32'(bad_addr), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Memory-side initiator that copies a block of words between two regions of the 64-word data memory through its single read/write port. It drives the memory's address, write-data and MemWrite/MemRead strobes and consumes its combinational read data. The processor or a test harness triggers it with a one-cycle start pulse and waits for a done pulse. Memory access alternates one read cycle and one write cycle per word.

## Interface
- DEPTH, 64, number of addressable words in the target memory; word-addressed.
- AW, 32, address width.
- DW, 32, data width.
- clk  in  1  single clock; all state changes on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  AW  first source word address; latched on accepted start.
- dst_addr  in  AW  first destination word address; latched on accepted start.
- len  in  7  word count, 0..64; latched on accepted start.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle pulse on completion, including error and zero-length cases.
- error  out  1  one-cycle pulse, coincident with done, for a range violation.
- words_done  out  7  words written so far in the current or last operation.
- mem_addr  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_write  out  1  MemWrite strobe.
- mem_read  out  1  MemRead strobe.
- mem_read_data  in  DW  memory read data; combinational from mem_addr.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with start=1:
  - Latch src, dst and len; clear the index i and words_done.
  - If len==0, go to DONE.
  - Else if src+len>DEPTH or dst+len>DEPTH (computed at AW+1 bits, no wrap), set the error flag and go to DONE.
  - Otherwise go to READ.
- READ: mem_addr=src+i, mem_read=1, mem_write=0. At the clock edge, capture mem_read_data into the data buffer and go to WRITE.
- WRITE: mem_addr=dst+i, mem_write_data=buffer, mem_write=1, mem_read=0. At the edge, i and words_done increment. Go to DONE if i+1==len, else to READ.
- DONE: done=1 and error=flag for this cycle only. Clear the flag and go to IDLE.
- start is ignored in every state except IDLE. Changes to src_addr, dst_addr or len after acceptance have no effect.
- Copy order is strictly ascending. Overlapping regions with dst>src produce forward-smear results; this is defined behaviour, not an error.
- On error or len==0, no mem_read or mem_write strobe is ever asserted.
- All outputs are decoded from registered state, buffer and index. No combinational path exists from start to memory strobes.
- In IDLE and DONE: mem_addr=0, mem_write_data=0, mem_write=0, mem_read=0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, error=0, words_done=0, mem_addr=0, mem_write_data=0, mem_write=0, mem_read=0.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronously).
  - Words written on edges before reset assertion remain in memory; no further write occurs.
- Start accepted at edge E0:
  - First READ cycle is E0..E1.
  - Word k is read in cycle 2k+1 and written at the end of cycle 2k+2.
  - done is high in cycle 2·len+1 after E0, i.e. total latency 2·len+1 cycles.
  - len==0 or error: done in cycle 1 after E0.
- busy is high for exactly 2·len cycles; mem_write is high for exactly len cycles.
- Earliest next accepted start is the edge ending the first IDLE cycle after DONE.
- Memory contract: read data is valid within the READ cycle. The write commits at the posedge ending the WRITE cycle.

## Test plan
Memory model reset image for all scenarios: mem[i]=i mod 32, except mem[5]=7.

- Basic copy: src=0, dst=40, len=8. Required: mem[40..47] = 0,1,2,3,4,7,6,7; done exactly 17 cycles after the start edge; 8 mem_write cycles; words_done=8; error=0.
- Zero length: len=0. Required: done=1 and error=0 in cycle 1; no strobes; memory unchanged.
- Range error: src=60, dst=0, len=8. Required: done=1 and error=1 in cycle 1; no strobes; memory unchanged. A following src=56, dst=0, len=8 copy succeeds with mem[0..7] = 24..31.
- Overlap: src=0, dst=1, len=4. Required: mem[0..4] = 0,0,0,0,0; mem[5] stays 7.
- Mid-operation reset: src=0, dst=40, len=8, with rst asserted during the 4th READ cycle. Required:
  - All outputs are 0 at once and busy=0.
  - mem[40..42] = 0,1,2; mem[43] is still 11.
  - After reset release, state is IDLE.
- Start while busy: pulse start with other operands during an active copy. Required: ignored; the first copy completes unchanged, and only one done pulse is produced.
